// File: rtl/wc_tile_feeder.sv
// Six-sample tile feeder for the WC stage. Tiles overlap by two samples and each is held for HOLD_CYC cycles.
// Optional feature: define WC_TILE_CNT_EN to make tile_idx count the tiles of the current row.
module wc_tile_feeder #(
  parameter int W        = 10,
  parameter int HOLD_CYC = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           in_ready,
  output logic [6*W-1:0] D,
  output logic           tile_valid,
  output logic           tile_last,
  output logic [7:0]     tile_idx
);

  typedef enum logic [1:0] {
    FILL_FIRST = 2'd0,
    FILL       = 2'd1,
    HOLD       = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] smp_reg   [6];
  logic [W-1:0] d_reg     [6];
  logic [W-1:0] tile_next [6];
  logic [2:0]   cnt_reg;
  logic [7:0]   hold_reg;
  logic         in_ready_reg, tile_valid_reg, tile_last_reg;
  logic         accept, complete, hold_done;

  assign accept    = in_valid && in_ready_reg;
  assign complete  = accept && ((cnt_reg == 3'd5) || in_last);
  assign hold_done = (state_reg == HOLD) && (hold_reg == 8'(HOLD_CYC - 1));

  // Positions past the incoming sample are zero, which covers the short final tile.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_pos
      assign tile_next[gi] = (cnt_reg == 3'(gi)) ? in_data :
                             (cnt_reg >  3'(gi)) ? smp_reg[gi] : '0;
      assign D[(6-gi)*W-1 -: W] = d_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      FILL_FIRST, FILL: if (complete) state_next = HOLD;
      HOLD:             if (hold_done) state_next = tile_last_reg ? FILL_FIRST : FILL;
      default:          state_next = FILL_FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= FILL_FIRST;
      in_ready_reg   <= 1'b0;
      tile_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      in_ready_reg   <= (state_next != HOLD);
      tile_valid_reg <= (state_next == HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) begin
        smp_reg[i] <= '0;
        d_reg[i]   <= '0;
      end
      cnt_reg       <= 3'd0;
      hold_reg      <= 8'd0;
      tile_last_reg <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 6; i++)
          if (cnt_reg == 3'(i)) smp_reg[i] <= in_data;
        cnt_reg <= cnt_reg + 3'd1;
      end
      if (complete) begin
        for (int i = 0; i < 6; i++) d_reg[i] <= tile_next[i];
        tile_last_reg <= in_last;
        hold_reg      <= 8'd0;
      end
      if (state_reg == HOLD) begin
        if (hold_done) begin
          tile_last_reg <= 1'b0;
          for (int i = 0; i < 6; i++) smp_reg[i] <= '0;
          // The tail of this tile seeds the next one unless the row just ended.
          if (!tile_last_reg) begin
            smp_reg[0] <= d_reg[4];
            smp_reg[1] <= d_reg[5];
            cnt_reg    <= 3'd2;
          end else begin
            cnt_reg    <= 3'd0;
          end
        end else begin
          hold_reg <= hold_reg + 8'd1;
        end
      end
    end
  end

`ifdef WC_TILE_CNT_EN
  logic [7:0] idx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           idx_reg <= 8'd0;
    else if (hold_done) idx_reg <= tile_last_reg ? 8'd0 : idx_reg + 8'd1;
  end

  assign tile_idx = idx_reg;
`else
  assign tile_idx = 8'd0;
`endif

  assign in_ready   = in_ready_reg;
  assign tile_valid = tile_valid_reg;
  assign tile_last  = tile_last_reg;

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Scoreboard bench for wc_tile_feeder: lane 0 uses HOLD_CYC=6, lane 1 uses HOLD_CYC=1 with back-to-back rows.
// Expected tiles come from a row-level model: tile k is row[4k..4k+5], zero past the row end.
module tb_wc_tile_feeder;
  localparam int W = 10;
  localparam int HOLD0 = 6;
  localparam int HOLD1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_s      [2];
  logic           in_valid_s [2];
  logic [W-1:0]   in_data_s  [2];
  logic           in_last_s  [2];
  logic           in_ready_s [2];
  logic [6*W-1:0] d_s        [2];
  logic           tv_s       [2];
  logic           tl_s       [2];
  logic [7:0]     idx_s      [2];

  wc_tile_feeder #(.W(W), .HOLD_CYC(HOLD0)) dut0 (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_data(in_data_s[0]),
    .in_last(in_last_s[0]), .in_ready(in_ready_s[0]), .D(d_s[0]),
    .tile_valid(tv_s[0]), .tile_last(tl_s[0]), .tile_idx(idx_s[0])
  );

  wc_tile_feeder #(.W(W), .HOLD_CYC(HOLD1)) dut1 (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_data(in_data_s[1]),
    .in_last(in_last_s[1]), .in_ready(in_ready_s[1]), .D(d_s[1]),
    .tile_valid(tv_s[1]), .tile_last(tl_s[1]), .tile_idx(idx_s[1])
  );

  typedef struct {
    int             lane;
    logic [6*W-1:0] d;
    logic           last;
    logic [7:0]     idx;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] row_q[$];
  int           checks = 0;
  int           errors = 0;

  bit             active [2];
  int             cyc    [2];
  logic [6*W-1:0] cap    [2];
  bit             stable [2];
  bit             rdy_ok [2];

  task automatic chk(input int l, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %h expected %h", l, name, act, exp);
    end else begin
      $display("ok   lane%0d %s: %h", l, name, act);
    end
  endtask

  task automatic fail_now(input int l, input string name);
    checks++;
    errors++;
    $display("FAIL lane%0d %s", l, name);
  endtask

  // Reference model: slice the whole row into stride-4, width-6 windows.
  task automatic push_row(input int l);
    int   n;
    int   k;
    int   s;
    exp_t e;
    n = row_q.size();
    k = 0;
    forever begin
      s = 4 * k;
      e.lane = l;
      e.d    = '0;
      for (int j = 0; j < 6; j++)
        if (s + j < n) e.d[(5-j)*W +: W] = row_q[s+j];
      e.last = (s + 6 >= n);
`ifdef WC_TILE_CNT_EN
      e.idx = 8'(k);
`else
      e.idx = 8'd0;
`endif
      exp_q.push_back(e);
      if (e.last) break;
      k++;
    end
  endtask

  task automatic drive_row(input int l, input bit with_last, input int max_gap);
    int g;
    int w;
    for (int i = 0; i < row_q.size(); i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin
        in_valid_s[l] = 1'b0;
        in_data_s[l]  = W'($urandom);
        in_last_s[l]  = 1'($urandom);
        @(negedge clk);
      end
      in_valid_s[l] = 1'b1;
      in_data_s[l]  = row_q[i];
      in_last_s[l]  = with_last && (i == row_q.size() - 1);
      w = 0;
      while (!in_ready_s[l] && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 1000) begin
        fail_now(l, "in_ready timeout");
        in_valid_s[l] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid_s[l] = 1'b0;
    in_last_s[l]  = 1'b0;
  endtask

  task automatic send_row(input int l, input int max_gap);
    push_row(l);
    drive_row(l, 1'b1, max_gap);
  endtask

  task automatic do_reset(input int l);
    rst_s[l] = 1'b0;
    #1;
    chk(l, "rst D", 64'(d_s[l]), 64'd0);
    chk(l, "rst tile_valid", 64'(tv_s[l]), 64'd0);
    chk(l, "rst tile_last", 64'(tl_s[l]), 64'd0);
    chk(l, "rst in_ready", 64'(in_ready_s[l]), 64'd0);
    chk(l, "rst tile_idx", 64'(idx_s[l]), 64'd0);
    @(negedge clk);
    rst_s[l] = 1'b1;
    @(negedge clk);
    chk(l, "in_ready after rst", 64'(in_ready_s[l]), 64'd1);
  endtask

  task automatic wait_drain(input int l);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || active[l]) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) fail_now(l, "drain timeout");
  endtask

  task automatic set_row(input int v0, input int v1, input int v2, input int v3, input int v4, input int v5);
    row_q = {};
    row_q.push_back(W'(v0)); row_q.push_back(W'(v1)); row_q.push_back(W'(v2));
    row_q.push_back(W'(v3)); row_q.push_back(W'(v4)); row_q.push_back(W'(v5));
  endtask

  task automatic set_ramp(input int n);
    row_q = {};
    for (int i = 1; i <= n; i++) row_q.push_back(W'(i));
  endtask

  task automatic set_random(input int n);
    row_q = {};
    for (int i = 0; i < n; i++) row_q.push_back(W'($urandom));
  endtask

  // Monitor: one pop per tile_valid rise, then duration/stability/ready checks on the fall.
  task automatic monitor();
    exp_t e;
    int   hc;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        hc = (l == 0) ? HOLD0 : HOLD1;
        if (!rst_s[l]) begin
          active[l] = 1'b0;
        end else if (tv_s[l] && !active[l]) begin
          active[l] = 1'b1;
          cyc[l]    = 1;
          cap[l]    = d_s[l];
          stable[l] = 1'b1;
          rdy_ok[l] = !in_ready_s[l];
          if (exp_q.size() == 0) begin
            fail_now(l, "unexpected tile");
          end else begin
            e = exp_q.pop_front();
            chk(l, "tile lane", 64'(l), 64'(e.lane));
            chk(l, "tile D", 64'(d_s[l]), 64'(e.d));
            chk(l, "tile_last", 64'(tl_s[l]), 64'(e.last));
            chk(l, "tile_idx", 64'(idx_s[l]), 64'(e.idx));
          end
        end else if (tv_s[l] && active[l]) begin
          cyc[l]++;
          if (d_s[l] !== cap[l]) stable[l] = 1'b0;
          if (in_ready_s[l]) rdy_ok[l] = 1'b0;
        end else if (!tv_s[l] && active[l]) begin
          active[l] = 1'b0;
          chk(l, "hold cycles", 64'(cyc[l]), 64'(hc));
          chk(l, "D stable in hold", 64'(stable[l]), 64'd1);
          chk(l, "in_ready low in hold", 64'(rdy_ok[l]), 64'd1);
        end
      end
    end
  endtask

  task automatic main_seq();
    // Lane 0: directed rows, aborted fill, then random rows with random gaps.
    do_reset(0);
    set_row(2, -10, 3, 4, -13, -18);
    send_row(0, 0);
    wait_drain(0);
    set_ramp(10);
    send_row(0, 1);
    set_ramp(7);
    send_row(0, 0);
    wait_drain(0);

    set_ramp(3);
    drive_row(0, 1'b0, 0);
    do_reset(0);
    set_row(-19, -6, 3, -9, -12, 11);
    send_row(0, 0);
    wait_drain(0);

    for (int r = 0; r < 30; r++) begin
      set_random(int'($urandom_range(1, 20)));
      send_row(0, 2);
    end
    wait_drain(0);

    // Lane 1: single-cycle hold and rows issued back to back.
    do_reset(1);
    set_ramp(10);
    send_row(1, 0);
    set_row(-1, -2, -3, -4, -5, -6);
    send_row(1, 0);
    for (int r = 0; r < 20; r++) begin
      set_random(int'($urandom_range(1, 14)));
      send_row(1, 0);
    end
    wait_drain(1);

    chk(0, "scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      rst_s[l]      = 1'b0;
      in_valid_s[l] = 1'b0;
      in_data_s[l]  = '0;
      in_last_s[l]  = 1'b0;
      active[l]     = 1'b0;
      cyc[l]        = 0;
      cap[l]        = '0;
      stable[l]     = 1'b1;
      rdy_ok[l]     = 1'b1;
    end
    @(negedge clk);
    fork
      monitor();
      main_seq();
    join_any
  end

endmodule
